// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - default parameter values for the controller and its match units
//   - FWD_REGFILE: forward-select code meaning "take operand from regfile"
//   - need_stall_f: per-source stall decision from a match result
package pipe_hazard_ctrl_pkg;

  localparam int unsigned DEPTH_DEF    = 3;
  localparam int unsigned REGW_DEF     = 5;
  localparam int unsigned LOAD_RDY_DEF = 2;
  localparam int unsigned CNTW_DEF     = 32;

  // Forward-select encoding 0 always means "no bypass, read regfile".
  localparam int unsigned FWD_REGFILE  = 0;

  // With forwarding, only a load still too young to have its data stalls;
  // without forwarding, any matching in-flight writer stalls.
  function automatic logic need_stall_f(input logic fwd_en,
                                        input logic hit,
                                        input logic is_load,
                                        input logic too_young);
    return hit & (~fwd_en | (is_load & too_young));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: compares one decode source register against the tracked
// writer slots and reports the youngest matching writer.
// Ports:
//   use_i   source is actually read        rs_i   source register index
//   vld_i   per-slot valid                 rd_i   per-slot destination
//   wrt_i   per-slot writes-rd             load_i per-slot is-load
//   hit_o   a writer matches               idx_o  slot number of youngest match
//   load_o  matching writer is a load
module hazard_match #(
  parameter int DEPTH     = 3,
  parameter int REGW      = 5,
  parameter int RF_BYPASS = 1,
  parameter int SELW      = 2
) (
  input  logic                       use_i,
  input  logic [REGW-1:0]            rs_i,
  input  logic [DEPTH:1]             vld_i,
  input  logic [DEPTH:1][REGW-1:0]   rd_i,
  input  logic [DEPTH:1]             wrt_i,
  input  logic [DEPTH:1]             load_i,
  output logic                       hit_o,
  output logic [SELW-1:0]            idx_o,
  output logic                       load_o
);

  // Scan oldest to youngest so the youngest (lowest slot) match is left last.
  // x0 never matches (rs != 0 together with rd == rs excludes rd == 0).
  // With a write-through regfile the oldest slot is already visible to D.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_i && (rs_i != '0) && vld_i[k] && wrt_i[k] && (rd_i[k] == rs_i)
          && ((k < DEPTH) || (RF_BYPASS == 0))) begin
        hit_o  = 1'b1;
        idx_o  = SELW'(k);
        load_o = load_i[k];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard control beside the decode stage of the 5-stage core.
// Tracks in-flight writers in slots 1..DEPTH (E, M, W), and produces decode
// stall, front-end flush, per-source forward selects and perf counters.
// Ports:
//   clk_i, reset_i (sync, active high)
//   id_valid_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
//   id_rd_i, id_regwrt_i, id_load_i    decode-stage instruction info
//   ex_redirect_i                      taken branch/jump resolved in slot 1
//   stall_o    hold PC and FD, DE takes bubble
//   flush_o    kill F and D
//   fwd_sel1_o, fwd_sel2_o   0 = regfile, k = result of slot k
//   stall_cnt_o, flush_cnt_o saturating cycle counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int REGW      = REGW_DEF,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int LOAD_RDY  = LOAD_RDY_DEF,
  parameter int CNTW      = CNTW_DEF,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [REGW-1:0]  id_rs1_i,
  input  logic [REGW-1:0]  id_rs2_i,
  input  logic             id_use1_i,
  input  logic             id_use2_i,
  input  logic [REGW-1:0]  id_rd_i,
  input  logic             id_regwrt_i,
  input  logic             id_load_i,
  input  logic             ex_redirect_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [SELW-1:0]  fwd_sel1_o,
  output logic [SELW-1:0]  fwd_sel2_o,
  output logic [CNTW-1:0]  stall_cnt_o,
  output logic [CNTW-1:0]  flush_cnt_o
);

  logic [DEPTH:1]            slot_vld_q, slot_vld_d;
  logic [DEPTH:1][REGW-1:0]  slot_rd_q, slot_rd_d;
  logic [DEPTH:1]            slot_wrt_q, slot_wrt_d;
  logic [DEPTH:1]            slot_load_q, slot_load_d;
  logic [CNTW-1:0]           stall_cnt_q, flush_cnt_q;

  logic            hit1_s, hit2_s, ld1_s, ld2_s, ns1_s, ns2_s;
  logic [SELW-1:0] idx1_s, idx2_s;

  hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .RF_BYPASS(RF_BYPASS), .SELW(SELW)) u_match1 (
    .use_i(id_use1_i), .rs_i(id_rs1_i), .vld_i(slot_vld_q), .rd_i(slot_rd_q),
    .wrt_i(slot_wrt_q), .load_i(slot_load_q),
    .hit_o(hit1_s), .idx_o(idx1_s), .load_o(ld1_s)
  );

  hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .RF_BYPASS(RF_BYPASS), .SELW(SELW)) u_match2 (
    .use_i(id_use2_i), .rs_i(id_rs2_i), .vld_i(slot_vld_q), .rd_i(slot_rd_q),
    .wrt_i(slot_wrt_q), .load_i(slot_load_q),
    .hit_o(hit2_s), .idx_o(idx2_s), .load_o(ld2_s)
  );

  // Stall/flush/forward decisions; a redirect kills D so it must never stall.
  always_comb begin
    ns1_s      = need_stall_f(FWD_EN != 0, hit1_s, ld1_s, int'(idx1_s) < LOAD_RDY);
    ns2_s      = need_stall_f(FWD_EN != 0, hit2_s, ld2_s, int'(idx2_s) < LOAD_RDY);
    stall_o    = id_valid_i & (ns1_s | ns2_s) & ~ex_redirect_i;
    flush_o    = ex_redirect_i;
    fwd_sel1_o = (FWD_EN != 0) ? idx1_s : SELW'(FWD_REGFILE);
    fwd_sel2_o = (FWD_EN != 0) ? idx2_s : SELW'(FWD_REGFILE);
  end

  // Slot shift: D enters slot 1 only when it really advances, else a bubble.
  always_comb begin
    slot_vld_d     = '0;
    slot_rd_d      = '0;
    slot_wrt_d     = '0;
    slot_load_d    = '0;
    slot_vld_d[1]  = id_valid_i & ~stall_o & ~flush_o;
    slot_rd_d[1]   = id_rd_i;
    slot_wrt_d[1]  = id_regwrt_i;
    slot_load_d[1] = id_load_i;
    for (int k = 2; k <= DEPTH; k++) begin
      slot_vld_d[k]  = slot_vld_q[k-1];
      slot_rd_d[k]   = slot_rd_q[k-1];
      slot_wrt_d[k]  = slot_wrt_q[k-1];
      slot_load_d[k] = slot_load_q[k-1];
    end
  end

  // Slot registers and saturating perf counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_vld_q  <= '0;
      slot_rd_q   <= '0;
      slot_wrt_q  <= '0;
      slot_load_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_rd_q   <= slot_rd_d;
      slot_wrt_q  <= slot_wrt_d;
      slot_load_q <= slot_load_d;
      if (stall_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
      if (flush_o && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default forwarding controller (dut) and an interlock-only
// variant (dut_il, FWD_EN=0) driven with the same decode stream.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use1, id_use2, id_regwrt, id_load, ex_redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic        stall, flush, il_stall, il_flush;
  logic [1:0]  sel1, sel2, il_sel1, il_sel2;
  logic [31:0] stall_cnt, flush_cnt, il_stall_cnt, il_flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use1_i(id_use1), .id_use2_i(id_use2),
    .id_rd_i(id_rd), .id_regwrt_i(id_regwrt), .id_load_i(id_load),
    .ex_redirect_i(ex_redirect),
    .stall_o(stall), .flush_o(flush), .fwd_sel1_o(sel1), .fwd_sel2_o(sel2),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(1)) dut_il (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use1_i(id_use1), .id_use2_i(id_use2),
    .id_rd_i(id_rd), .id_regwrt_i(id_regwrt), .id_load_i(id_load),
    .ex_redirect_i(ex_redirect),
    .stall_o(il_stall), .flush_o(il_flush), .fwd_sel1_o(il_sel1), .fwd_sel2_o(il_sel2),
    .stall_cnt_o(il_stall_cnt), .flush_cnt_o(il_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decode-stage instruction (v=valid, u1/u2=sources used).
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wrt, input logic ld, input logic redir);
    id_valid = v;  id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_rd = rd;    id_regwrt = wrt; id_load = ld; ex_redirect = redir;
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #1;
    // 1. reset state
    do_reset();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_sel1", {30'd0, sel1}, 32'd0);
    chk("rst_sel2", {30'd0, sel2}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);

    // 2. add x5,x1,x2 ; add x6,x5,x5 -> forward from slot 1, no stall
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("alu_first_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("alu_use_stall", {31'd0, stall}, 32'd0);
    chk("alu_use_sel1", {30'd0, sel1}, 32'd1);
    chk("alu_use_sel2", {30'd0, sel2}, 32'd1);
    tick();

    // 3. lw x5 ; add x6,x5,x1 -> one stall cycle, then forward from slot 2
    do_reset();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("ld_use_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("ld_use_release", {31'd0, stall}, 32'd0);
    chk("ld_use_sel1", {30'd0, sel1}, 32'd2);
    chk("ld_use_sel2", {30'd0, sel2}, 32'd0);
    chk("ld_use_stall_cnt", stall_cnt, 32'd1);
    tick();

    // 4. interlock variant: add x5 ; use x5 -> two stall cycles
    do_reset();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("il_stall_c1", {31'd0, il_stall}, 32'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("il_stall_c2", {31'd0, il_stall}, 32'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("il_release", {31'd0, il_stall}, 32'd0);
    chk("il_sel1", {30'd0, il_sel1}, 32'd0);
    chk("il_stall_cnt", il_stall_cnt, 32'd2);
    tick();

    // 5. load-use coincident with redirect -> flush wins, slot 1 gets a bubble
    do_reset();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    chk("redir_stall", {31'd0, stall}, 32'd0);
    chk("redir_flush", {31'd0, flush}, 32'd1);
    tick();
    // reads x6 (killed add would be slot 1) and x5 (lw now in slot 2)
    drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("redir_bubble_sel1", {30'd0, sel1}, 32'd0);
    chk("redir_ld_sel2", {30'd0, sel2}, 32'd2);
    chk("redir_after_stall", {31'd0, stall}, 32'd0);
    chk("redir_after_flush", {31'd0, flush}, 32'd0);
    chk("redir_flush_cnt", flush_cnt, 32'd1);
    tick();

    // 6. x0 never hazards; youngest of two writers of x5 wins
    do_reset();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("x0_stall", {31'd0, stall}, 32'd0);
    chk("x0_sel1", {30'd0, sel1}, 32'd0);
    chk("x0_sel2", {30'd0, sel2}, 32'd0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("young_sel1", {30'd0, sel1}, 32'd1);
    chk("young_sel2", {30'd0, sel2}, 32'd1);
    chk("young_stall", {31'd0, stall}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
